// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter (8N1) on the core data bus.
// DATA at BASE_ADDR pushes a byte into the TX FIFO; STATUS at BASE_ADDR+4
// reports full/empty/busy/overflow/count and clears overflow on write.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit before STOP.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rd_en,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q;
  logic            tx_q;
  logic [TW-1:0]   timer_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;

  logic            full, empty, busy;
  logic [PW-1:0]   count;
  logic [3:0]      cnt4;
  logic            data_wr, stat_wr, push, drop, clr, pop;
  logic [7:0]      status;
  logic            unused_bits;

  assign unused_bits = ^{wdata[31:8], addr[1:0], wmask[3:1]};

  // Address decode and bus strobes
  assign sel     = (addr[31:3] == BASE_ADDR[31:3]);
  assign data_wr = sel & ~addr[2] & wmask[0];
  assign stat_wr = sel &  addr[2] & wmask[0];

  // FIFO flags from registered pointers
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign busy  = (state_q != S_IDLE);

  assign push = data_wr & ~full;
  assign drop = data_wr &  full;
  assign clr  = stat_wr & wdata[3];
  assign pop  = (state_q == S_IDLE) & ~empty;

  // Saturating 4-bit count field, safe for any pointer width
  always_comb begin
    cnt4 = '0;
    for (int unsigned i = 0; i < PW && i < 4; i++) cnt4[i] = count[i];
    if (32'(count) > 32'd15) cnt4 = '1;
  end

  assign status = {cnt4, ovf_q, busy, empty, full};
  assign rdata  = (sel && rd_en) ? {24'b0, status} : '0;
  assign tx     = tx_q;

  // Next-state for FIFO pointers and sticky overflow (set beats clear)
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ovf_d    = ovf_q;
    if (clr)  ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  // FIFO pointer and overflow registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata[7:0];
  end

  // Transmit FSM with registered tx: each state drives tx for the next period
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      tx_q     <= 1'b1;
      timer_q  <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q[AW-1:0]];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^mem_q[rd_ptr_q[AW-1:0]];
`endif
            timer_q  <= TMAX;
            tx_q     <= 1'b0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (timer_q == '0) begin
            timer_q <= TMAX;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_DATA: begin
          if (timer_q == '0) begin
            timer_q <= TMAX;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (timer_q == '0) begin
            timer_q <= TMAX;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
`endif
        S_STOP: begin
          if (timer_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;
  logic        rd_en, sel, tx;

  int vectors = 0;
  int errors  = 0;

  mmio_uart_tx #(
    .BASE_ADDR    (32'h0000_0400),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .wmask (wmask),
    .rd_en (rd_en),
    .sel   (sel),
    .rdata (rdata),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  // Expected line level at cycle k of a frame carrying byte b
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    addr  = '0;
    wdata = '0;
    wmask = '0;
    rd_en = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wmask = 4'b0001;
    rd_en = 1'b0;
    tick();
    bus_idle();
  endtask

  task automatic get_status(output logic [31:0] v);
    addr  = 32'h0000_0404;
    rd_en = 1'b1;
    #1;
    v = rdata;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] st;
    reset = 1'b1;
    bus_idle();
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b expected 1", tx);
    end
    get_status(st);
    vectors++;
    if (st !== 32'h02) begin
      errors++;
      $display("FAIL reset_status: got %h expected 00000002", st);
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    logic [31:0] st;
    store(32'h0000_0400, {24'h0, b});
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL single_latency1: tx=%b expected 1", tx);
    end
    tick();
    for (int k = 0; k < FRAME; k++) begin
      vectors++;
      if (tx !== exp_tx(b, k)) begin
        errors++;
        $display("FAIL single_%h_k%0d: tx=%b expected %b", b, k, tx, exp_tx(b, k));
      end
      tick();
    end
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL single_after_tx: tx=%b expected 1", tx);
    end
    get_status(st);
    vectors++;
    if (st !== 32'h02) begin
      errors++;
      $display("FAIL single_status: got %h expected 00000002", st);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] st;
    logic [7:0]  bytes [3];
    int          k0;
    bytes = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) store(32'h0000_0400, {24'h0, bytes[i]});
    get_status(st);
    vectors++;
    if (st !== 32'h24) begin
      errors++;
      $display("FAIL b2b_mid_status: got %h expected 00000024", st);
    end
    k0 = 1;
    for (int f = 0; f < 3; f++) begin
      for (int k = k0; k < FRAME; k++) begin
        vectors++;
        if (tx !== exp_tx(bytes[f], k)) begin
          errors++;
          $display("FAIL b2b_f%0d_k%0d: tx=%b expected %b", f, k, tx, exp_tx(bytes[f], k));
        end
        tick();
      end
      vectors++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle%0d: tx=%b expected 1", f, tx);
      end
      tick();
      k0 = 0;
    end
    get_status(st);
    vectors++;
    if (st !== 32'h02) begin
      errors++;
      $display("FAIL b2b_end_status: got %h expected 00000002", st);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] st;
    logic [7:0]  bytes [5];
    int          k0;
    bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    for (int i = 0; i < 5; i++) store(32'h0000_0400, {24'h0, bytes[i]});
    store(32'h0000_0400, 32'h0000_0015);
    get_status(st);
    vectors++;
    if (st !== 32'h4D) begin
      errors++;
      $display("FAIL ovf_status: got %h expected 0000004d", st);
    end
    store(32'h0000_0404, 32'h0000_0008);
    get_status(st);
    vectors++;
    if (st !== 32'h45) begin
      errors++;
      $display("FAIL ovf_clear: got %h expected 00000045", st);
    end
    store(32'h0000_0400, 32'h0000_0099);
    get_status(st);
    vectors++;
    if (st !== 32'h4D) begin
      errors++;
      $display("FAIL ovf_reset_after_clear: got %h expected 0000004d", st);
    end
    store(32'h0000_0404, 32'hFFFF_FFF7);
    get_status(st);
    vectors++;
    if (st !== 32'h4D) begin
      errors++;
      $display("FAIL ovf_no_clear_bit3_0: got %h expected 0000004d", st);
    end
    k0 = 7;
    for (int f = 0; f < 5; f++) begin
      for (int k = k0; k < FRAME; k++) begin
        vectors++;
        if (tx !== exp_tx(bytes[f], k)) begin
          errors++;
          $display("FAIL ovf_f%0d_k%0d: tx=%b expected %b", f, k, tx, exp_tx(bytes[f], k));
        end
        tick();
      end
      vectors++;
      if (tx !== 1'b1) begin
        errors++;
        $display("FAIL ovf_idle%0d: tx=%b expected 1", f, tx);
      end
      tick();
      k0 = 0;
    end
    get_status(st);
    vectors++;
    if (st !== 32'h0A) begin
      errors++;
      $display("FAIL ovf_end_status: got %h expected 0000000a", st);
    end
    store(32'h0000_0404, 32'h0000_0008);
    get_status(st);
    vectors++;
    if (st !== 32'h02) begin
      errors++;
      $display("FAIL ovf_final_clear: got %h expected 00000002", st);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] st;
    logic        stuck;
    store(32'h0000_0400, 32'h0000_00A5);
    store(32'h0000_0400, 32'h0000_005A);
    repeat (15) tick();
    vectors++;
    if (tx !== exp_tx(8'hA5, 15)) begin
      errors++;
      $display("FAIL rst_mid_k15: tx=%b expected %b", tx, exp_tx(8'hA5, 15));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_tx: tx=%b expected 1", tx);
    end
    get_status(st);
    vectors++;
    if (st !== 32'h02) begin
      errors++;
      $display("FAIL rst_mid_status: got %h expected 00000002", st);
    end
    stuck = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) stuck = 1'b1;
      tick();
    end
    vectors++;
    if (stuck !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_no_frames: tx left idle=%b expected 0", stuck);
    end
  endtask

  task automatic test_decode();
    logic [31:0] st;
    addr  = 32'h0000_0800;
    rd_en = 1'b1;
    #1;
    vectors++;
    if (sel !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL dec_0x800: sel=%b rdata=%h expected sel=0 rdata=0", sel, rdata);
    end
    addr = 32'h0000_0403;
    #1;
    vectors++;
    if (sel !== 1'b1 || rdata !== 32'h02) begin
      errors++;
      $display("FAIL dec_data_read: sel=%b rdata=%h expected sel=1 rdata=2", sel, rdata);
    end
    addr = 32'h0000_0407;
    #1;
    vectors++;
    if (sel !== 1'b1 || rdata !== 32'h02) begin
      errors++;
      $display("FAIL dec_status_read: sel=%b rdata=%h expected sel=1 rdata=2", sel, rdata);
    end
    addr = 32'h0000_0408;
    #1;
    vectors++;
    if (sel !== 1'b0) begin
      errors++;
      $display("FAIL dec_0x408: sel=%b expected 0", sel);
    end
    bus_idle();
    store(32'h0000_0800, 32'h0000_0033);
    repeat (3) tick();
    get_status(st);
    vectors++;
    if (st !== 32'h02 || tx !== 1'b1) begin
      errors++;
      $display("FAIL dec_foreign_store: status=%h tx=%b expected 00000002 1", st, tx);
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h55);
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_decode();
    test_single(8'h07);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
